// File: rtl/biriscv_uart_pkg.sv
`default_nettype none
// ============================================================================
// biriscv_uart_pkg : shared types and constants for the UART receive path
// Revision 1.0
// ============================================================================
package biriscv_uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int SAMPLE_POINT = 7;
    localparam int OVERSAMPLE   = 16;

    // Clocks per oversample tick
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// uart_byte_fifo : first-word fall-through byte FIFO, empty reads as zero
// Revision 1.0
// ============================================================================
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [7:0]             data_i,
    input  logic                   pop_i,
    output logic [7:0]             data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_push;
    logic             w_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when a pop frees the head slot
    assign w_pop  = pop_i && !empty_o;
    assign w_push = push_i && (!full_o || w_pop);

    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_stage.sv
`default_nettype none
// ============================================================================
// uart_rx_stage : 8N1 receiver with 16x oversampling and an output byte FIFO
// Revision 1.0
// ============================================================================
module uart_rx_stage #(
    parameter int CLK_HZ = 14745600,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic                   Clk_14_7456MHz,
    input  logic                   sys_rst_n,
    input  logic                   RX,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic                   frame_err,
    output logic                   overrun
);
    import biriscv_uart_pkg::*;

    localparam int               DIV       = calc_div(CLK_HZ, BAUD);
    localparam int               DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [3:0]       SC_SAMPLE = 4'(SAMPLE_POINT);
    localparam logic [3:0]       SC_LAST   = 4'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_START = START;
    localparam logic [2:0] S_DATA  = DATA;
    localparam logic [2:0] S_STOP  = STOP;
    localparam logic [2:0] S_BREAK = BREAK;

    logic             rx_meta_q;
    logic             rx_s_q;
    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       sc_q, sc_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic             w_tick;
    logic             w_sample;
    logic             w_bit_end;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    assign w_tick    = (state_q != S_IDLE) && (div_q == DIV_LAST);
    assign w_sample  = w_tick && (sc_q == SC_SAMPLE);
    assign w_bit_end = w_tick && (sc_q == SC_LAST);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        sc_d        = sc_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        w_push      = 1'b0;

        if (state_q != S_IDLE) begin
            div_d = w_tick ? '0 : div_q + DIV_W'(1);
            if (w_tick) begin
                sc_d = sc_q + 4'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                // Counters restart here so every sample point is 8*DIV into its bit
                if (!rx_s_q) begin
                    state_d = S_START;
                    div_d   = '0;
                    sc_d    = '0;
                end
            end
            S_START: begin
                if (w_sample && rx_s_q) begin
                    state_d = S_IDLE;
                end else if (w_bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (w_sample) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                end
                if (w_bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Leaving at mid-stop gives half a bit to catch a back-to-back start
                if (w_sample) begin
                    if (rx_s_q) begin
                        w_push  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rx_valid  = !w_empty;
    assign w_pop     = rx_valid && rx_ready;
    assign overrun_d = w_push && w_full && !w_pop;

    always_ff @(posedge Clk_14_7456MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            div_q       <= '0;
            sc_q        <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= RX;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            div_q       <= div_d;
            sc_q        <= sc_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (Clk_14_7456MHz),
        .rst_ni  (sys_rst_n),
        .push_i  (w_push),
        .data_i  (shift_q),
        .pop_i   (w_pop),
        .data_o  (rx_data),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (rx_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_stage.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_stage : scoreboard bench for the UART receive stage
// Revision 1.0
// ============================================================================
module tb_uart_rx_stage;
    localparam int BIT_CLKS = 128;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx_line  = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [4:0] rx_count;
    logic       frame_err;
    logic       overrun;

    int         n_cmp     = 0;
    int         n_bad     = 0;
    int         ferr_seen = 0;
    int         ovr_seen  = 0;
    logic       ferr_prev = 1'b0;
    logic       ovr_prev  = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_stage #(
        .CLK_HZ (14745600),
        .BAUD   (115200),
        .DEPTH  (16)
    ) dut (
        .Clk_14_7456MHz (clk),
        .sys_rst_n      (rst_n),
        .RX             (rx_line),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_count       (rx_count),
        .frame_err      (frame_err),
        .overrun        (overrun)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output byte is matched against the queue head
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_byte: got 0x%0h, expected no output", rx_data);
                end else begin
                    check("rx_data", int'(rx_data), int'(exp_q.pop_front()));
                end
            end
            if (frame_err) begin
                ferr_seen++;
                check("frame_err_width", int'(ferr_prev), 0);
            end
            if (overrun) begin
                ovr_seen++;
                check("overrun_width", int'(ovr_prev), 0);
            end
            ferr_prev = frame_err;
            ovr_prev  = overrun;
        end else begin
            ferr_prev = 1'b0;
            ovr_prev  = 1'b0;
        end
    end

    task automatic send_frame(input logic [7:0] b, input int stop_low);
        @(posedge clk); #1 rx_line = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT_CLKS) @(posedge clk);
            #1 rx_line = b[i];
        end
        repeat (BIT_CLKS) @(posedge clk);
        #1 rx_line = (stop_low == 0);
        repeat (BIT_CLKS * ((stop_low > 0) ? stop_low : 1)) @(posedge clk);
        #1 rx_line = 1'b1;
        if (stop_low > 0) begin
            repeat (BIT_CLKS) @(posedge clk);
        end
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int max_clks);
        for (int i = 0; i < max_clks && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        check(name, exp_q.size(), 0);
    endtask

    // Holds rx_ready for exactly the cycle in which the stop-bit push is decided
    task automatic pop_at_push();
        repeat (1219) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    int ferr_before;
    int ovr_before;

    initial begin
        idle_clks(3);
        check("reset_rx_data",   int'(rx_data),   0);
        check("reset_rx_valid",  int'(rx_valid),  0);
        check("reset_rx_count",  int'(rx_count),  0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_overrun",   int'(overrun),   0);
        rst_n = 1'b1;
        idle_clks(5);

        // Back-to-back frames with an always-ready consumer
        rx_ready = 1'b1;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA3);
        send_frame(8'h55, 0);
        send_frame(8'hA3, 0);
        idle_clks(2 * BIT_CLKS);
        wait_drain("drain_55_a3", 100);
        check("t1_frame_err_cnt", ferr_seen, 0);
        check("t1_overrun_cnt",   ovr_seen,  0);
        check("t1_rx_count",      int'(rx_count), 0);

        // Three-clock glitch must be rejected
        @(posedge clk); #1 rx_line = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx_line = 1'b1;
        idle_clks(200);
        check("glitch_rx_count", int'(rx_count), 0);
        check("glitch_rx_valid", int'(rx_valid), 0);

        // Long-low stop bit, then a clean frame
        send_frame(8'h3C, 2);
        check("ferr_rx_count", int'(rx_count), 0);
        check("ferr_cnt",      ferr_seen, 1);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 0);
        idle_clks(BIT_CLKS);
        wait_drain("drain_12", 100);
        check("ferr_cnt_after", ferr_seen, 1);

        // Fill with the consumer stalled, then overrun on the 17th byte
        rx_ready = 1'b0;
        for (int b = 0; b < 17; b++) begin
            if (b == 16) begin
                check("full_rx_count",     int'(rx_count), 16);
                check("full_overrun_none", ovr_seen, 0);
            end else begin
                exp_q.push_back(8'(b));
            end
            send_frame(8'(b), 0);
        end
        idle_clks(BIT_CLKS);
        check("ovr_cnt",        ovr_seen, 1);
        check("ovr_rx_count",   int'(rx_count), 16);
        check("ovr_head",       int'(rx_data), 8'h00);
        check("ovr_rx_valid",   int'(rx_valid), 1);

        // Simultaneous push and pop while full
        exp_q.push_back(8'h11);
        fork
            send_frame(8'h11, 0);
            pop_at_push();
        join
        idle_clks(BIT_CLKS);
        check("pushpop_rx_count", int'(rx_count), 16);
        check("pushpop_ovr_cnt",  ovr_seen, 1);
        rx_ready = 1'b1;
        wait_drain("drain_full", 64);
        check("drained_rx_count", int'(rx_count), 0);
        check("drained_rx_data",  int'(rx_data), 0);
        check("drained_rx_valid", int'(rx_valid), 0);

        // Asynchronous reset in the middle of a frame with bytes buffered
        rx_ready = 1'b0;
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hB2);
        exp_q.push_back(8'hC3);
        send_frame(8'hA1, 0);
        send_frame(8'hB2, 0);
        send_frame(8'hC3, 0);
        idle_clks(10);
        check("prerst_rx_count", int'(rx_count), 3);
        ferr_before = ferr_seen;
        ovr_before  = ovr_seen;
        @(posedge clk); #1 rx_line = 1'b0;
        repeat (400) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_rx_count",  int'(rx_count),  0);
        check("arst_rx_valid",  int'(rx_valid),  0);
        check("arst_rx_data",   int'(rx_data),   0);
        check("arst_frame_err", int'(frame_err), 0);
        check("arst_overrun",   int'(overrun),   0);
        exp_q.delete();
        rx_line = 1'b1;
        idle_clks(4);
        rst_n = 1'b1;
        idle_clks(4);
        rx_ready = 1'b1;
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 0);
        idle_clks(BIT_CLKS);
        wait_drain("drain_ff", 100);
        check("post_rst_ferr", ferr_seen, ferr_before);
        check("post_rst_ovr",  ovr_seen,  ovr_before);
        check("post_rst_count", int'(rx_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
